// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl: hazard detection and forwarding control for the 5-stage
// F/D/E/M/W pipeline. It drives the forwarding mux selects, the D-stage
// stall, and the busy sequencing of the multi-cycle mult/div unit.
// Optional feature: define HAZ_PERF_EN to count stall cycles on stall_cnt.
module hazard_fwd_ctrl #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs_D,
    input  logic [4:0]  rt_D,
    input  logic [1:0]  tuse_rs_D,
    input  logic [1:0]  tuse_rt_D,
    input  logic [4:0]  rs_E,
    input  logic [4:0]  rt_E,
    input  logic [4:0]  rt_M,
    input  logic [4:0]  A3_E,
    input  logic [4:0]  A3_M,
    input  logic [4:0]  A3_W,
    input  logic [1:0]  res_E,
    input  logic [1:0]  res_M,
    input  logic [1:0]  res_W,
    input  logic        md_use_D,
    input  logic        md_start_E,
    input  logic        md_div_E,
    output logic        stall,
    output logic [2:0]  MCMP1D,
    output logic [2:0]  MCMP2D,
    output logic [2:0]  MALUAE,
    output logic [2:0]  MALUBE,
    output logic [2:0]  MWDM,
    output logic        md_busy,
    output logic [31:0] stall_cnt
);

    localparam logic [1:0] RES_NONE = 2'd0;
    localparam logic [1:0] RES_ALU  = 2'd1;
    localparam logic [1:0] RES_DM   = 2'd2;
    localparam logic [1:0] RES_PC   = 2'd3;
    localparam logic [1:0] TUSE_NONE = 2'd3;

    localparam logic [2:0] SEL_RF    = 3'd0;
    localparam logic [2:0] SEL_M_ALU = 3'd1;
    localparam logic [2:0] SEL_M_PC  = 3'd2;
    localparam logic [2:0] SEL_W_ALU = 3'd3;
    localparam logic [2:0] SEL_W_DM  = 3'd4;
    localparam logic [2:0] SEL_W_PC  = 3'd5;

    localparam logic [3:0] MULT_LD = 4'(MULT_CYC);
    localparam logic [3:0] DIV_LD  = 4'(DIV_CYC);

    logic [3:0] cnt;
    logic       data_stall;
    logic       md_stall;

    // A stage produces reg r only if it writes a non-zero register with a real result.
    function automatic logic hit(input logic [4:0] r, input logic [4:0] a3,
                                 input logic [1:0] res);
        return (r != 5'd0) && (r == a3) && (res != RES_NONE);
    endfunction

    // Cycles until the result is available, counted from the E stage.
    function automatic logic [1:0] tnew_e(input logic [1:0] res);
        return (res == RES_DM) ? 2'd2 : ((res == RES_NONE) ? 2'd0 : 2'd1);
    endfunction

    // Only a load still in M has a result that is not yet ready.
    function automatic logic [1:0] tnew_m(input logic [1:0] res);
        return (res == RES_DM) ? 2'd1 : 2'd0;
    endfunction

    // Stall when the producer in E or M cannot deliver before the consumer needs it.
    function automatic logic reg_stall(input logic [4:0] r, input logic [1:0] tuse,
                                       input logic [4:0] a3e, input logic [1:0] rese,
                                       input logic [4:0] a3m, input logic [1:0] resm);
        if (tuse == TUSE_NONE) return 1'b0;
        return (hit(r, a3e, rese) && (tnew_e(rese) > tuse)) ||
               (hit(r, a3m, resm) && (tnew_m(resm) > tuse));
    endfunction

    // W-stage source select; M-stage loads fall through here because the stall covers them.
    function automatic logic [2:0] fwd_w(input logic [4:0] r, input logic [4:0] a3w,
                                         input logic [1:0] resw);
        if (!hit(r, a3w, resw)) return SEL_RF;
        case (resw)
            RES_ALU: return SEL_W_ALU;
            RES_DM:  return SEL_W_DM;
            default: return SEL_W_PC;
        endcase
    endfunction

    // Youngest producer wins: M (ALU/PC only) before W.
    function automatic logic [2:0] fwd_mw(input logic [4:0] r,
                                          input logic [4:0] a3m, input logic [1:0] resm,
                                          input logic [4:0] a3w, input logic [1:0] resw);
        if (hit(r, a3m, resm) && (resm == RES_ALU)) return SEL_M_ALU;
        if (hit(r, a3m, resm) && (resm == RES_PC))  return SEL_M_PC;
        return fwd_w(r, a3w, resw);
    endfunction

    // Stall and forwarding selects are purely combinational on the pipeline state.
    always_comb begin
        data_stall = reg_stall(rs_D, tuse_rs_D, A3_E, res_E, A3_M, res_M) ||
                     reg_stall(rt_D, tuse_rt_D, A3_E, res_E, A3_M, res_M);
        md_stall   = md_use_D && (md_busy || md_start_E);
        stall      = data_stall || md_stall;
        MCMP1D     = fwd_mw(rs_D, A3_M, res_M, A3_W, res_W);
        MCMP2D     = fwd_mw(rt_D, A3_M, res_M, A3_W, res_W);
        MALUAE     = fwd_mw(rs_E, A3_M, res_M, A3_W, res_W);
        MALUBE     = fwd_mw(rt_E, A3_M, res_M, A3_W, res_W);
        MWDM       = fwd_w(rt_M, A3_W, res_W);
    end

    // MDU busy counter: a new start always reloads, otherwise count down to idle.
    always_ff @(posedge clk) begin
        if (reset)
            cnt <= 4'd0;
        else if (md_start_E)
            cnt <= md_div_E ? DIV_LD : MULT_LD;
        else if (cnt != 4'd0)
            cnt <= cnt - 4'd1;
    end

    assign md_busy = (cnt != 4'd0);

`ifdef HAZ_PERF_EN
    logic [31:0] perf_q;

    // Saturating count of stalled cycles.
    always_ff @(posedge clk) begin
        if (reset)
            perf_q <= 32'h0;
        else if (stall && (perf_q != 32'hFFFF_FFFF))
            perf_q <= perf_q + 32'd1;
    end

    assign stall_cnt = perf_q;
`else
    assign stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// tb_hazard_fwd_ctrl: table-driven check of the stall/forwarding decode plus
// hand-written clocked sequences for the MDU counter and the stall counter.
module tb_hazard_fwd_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rs_D, rt_D, rs_E, rt_E, rt_M, A3_E, A3_M, A3_W;
    logic [1:0]  tuse_rs_D, tuse_rt_D, res_E, res_M, res_W;
    logic        md_use_D, md_start_E, md_div_E;
    logic        stall, md_busy;
    logic [2:0]  MCMP1D, MCMP2D, MALUAE, MALUBE, MWDM;
    logic [31:0] stall_cnt;

    int checks = 0;
    int errors = 0;

`ifdef HAZ_PERF_EN
    localparam logic [31:0] EXP_PERF7 = 32'd7;
`else
    localparam logic [31:0] EXP_PERF7 = 32'd0;
`endif

    always #5 clk = ~clk;

    hazard_fwd_ctrl dut (
        .clk(clk), .reset(reset),
        .rs_D(rs_D), .rt_D(rt_D), .tuse_rs_D(tuse_rs_D), .tuse_rt_D(tuse_rt_D),
        .rs_E(rs_E), .rt_E(rt_E), .rt_M(rt_M),
        .A3_E(A3_E), .A3_M(A3_M), .A3_W(A3_W),
        .res_E(res_E), .res_M(res_M), .res_W(res_W),
        .md_use_D(md_use_D), .md_start_E(md_start_E), .md_div_E(md_div_E),
        .stall(stall), .MCMP1D(MCMP1D), .MCMP2D(MCMP2D),
        .MALUAE(MALUAE), .MALUBE(MALUBE), .MWDM(MWDM),
        .md_busy(md_busy), .stall_cnt(stall_cnt)
    );

    typedef struct {
        logic [4:0] rs_d, rt_d;
        logic [1:0] tr, tt;
        logic [4:0] rs_e, rt_e, rt_m, a3e, a3m, a3w;
        logic [1:0] rese, resm, resw;
        logic       e_stall;
        logic [2:0] e_c1, e_c2, e_ae, e_be, e_wd;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs[NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_pipe();
        rs_D = 0; rt_D = 0; tuse_rs_D = 3; tuse_rt_D = 3;
        rs_E = 0; rt_E = 0; rt_M = 0; A3_E = 0; A3_M = 0; A3_W = 0;
        res_E = 0; res_M = 0; res_W = 0;
    endtask

    // Expect md_busy (and the mfhi stall) for exactly n cycles, then both low.
    task automatic busy_window(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            chk($sformatf("%s_busy%0d", tag, k), 32'(md_busy), 32'd1);
            chk($sformatf("%s_stall%0d", tag, k), 32'(stall), 32'd1);
            step();
        end
        chk({tag, "_busy_end"}, 32'(md_busy), 32'd0);
        chk({tag, "_stall_end"}, 32'(stall), 32'd0);
    endtask

    initial begin
        //          rsD rtD tr tt rsE rtE rtM a3E a3M a3W rE rM rW  st c1 c2 ae be wd
        vecs[0]  = '{1,  0, 0, 3,  0,  0,  0,  1,  0,  0, 2, 0, 0,  1, 0, 0, 0, 0, 0};
        vecs[1]  = '{1,  0, 0, 3,  0,  0,  0,  0,  1,  0, 0, 2, 0,  1, 0, 0, 0, 0, 0};
        vecs[2]  = '{1,  0, 0, 3,  0,  0,  0,  0,  0,  1, 0, 0, 2,  0, 4, 0, 0, 0, 0};
        vecs[3]  = '{0,  2, 3, 0,  0,  0,  0,  0,  2,  0, 0, 1, 0,  0, 0, 1, 0, 0, 0};
        vecs[4]  = '{0,  2, 3, 0,  0,  0,  0,  0,  2,  2, 0, 1, 1,  0, 0, 1, 0, 0, 0};
        vecs[5]  = '{0,  0, 3, 3, 31,  0,  0,  0,  0, 31, 0, 0, 3,  0, 0, 0, 5, 0, 0};
        vecs[6]  = '{0,  0, 3, 3,  0,  0,  0,  0,  0,  0, 0, 1, 3,  0, 0, 0, 0, 0, 0};
        vecs[7]  = '{0,  5, 3, 2,  0,  0,  0,  5,  0,  0, 2, 0, 0,  0, 0, 0, 0, 0, 0};
        vecs[8]  = '{0,  5, 3, 1,  0,  0,  0,  5,  0,  0, 2, 0, 0,  1, 0, 0, 0, 0, 0};
        vecs[9]  = '{3,  0, 0, 3,  0,  0,  0,  3,  0,  0, 1, 0, 0,  1, 0, 0, 0, 0, 0};
        vecs[10] = '{3,  0, 1, 3,  0,  0,  0,  3,  0,  0, 1, 0, 0,  0, 0, 0, 0, 0, 0};
        vecs[11] = '{3,  0, 3, 3,  0,  0,  0,  3,  0,  0, 2, 0, 0,  0, 0, 0, 0, 0, 0};
        vecs[12] = '{0,  0, 0, 0,  0,  0,  0,  0,  0,  0, 2, 1, 1,  0, 0, 0, 0, 0, 0};
        vecs[13] = '{4,  0, 0, 3,  0,  0,  0,  4,  0,  0, 0, 0, 0,  0, 0, 0, 0, 0, 0};
        vecs[14] = '{0,  0, 3, 3,  7,  7,  0,  0,  7,  0, 0, 3, 0,  0, 0, 0, 2, 2, 0};
        vecs[15] = '{0,  0, 3, 3,  0,  0,  8,  0,  8,  8, 0, 1, 2,  0, 0, 0, 0, 0, 4};
        vecs[16] = '{0,  0, 3, 3,  9,  0,  9,  0,  0,  9, 0, 0, 1,  0, 0, 0, 3, 0, 3};
        vecs[17] = '{6,  6, 1, 0,  0,  0,  0,  0,  6,  0, 0, 2, 0,  1, 0, 0, 0, 0, 0};

        clear_pipe();
        md_use_D = 0; md_start_E = 0; md_div_E = 0;
        reset = 1;
        step();
        step();
        chk("rst_busy", 32'(md_busy), 32'd0);
        chk("rst_stall_cnt", stall_cnt, 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        reset = 0;

        // Combinational decode table.
        for (int i = 0; i < NV; i++) begin
            rs_D = vecs[i].rs_d; rt_D = vecs[i].rt_d;
            tuse_rs_D = vecs[i].tr; tuse_rt_D = vecs[i].tt;
            rs_E = vecs[i].rs_e; rt_E = vecs[i].rt_e; rt_M = vecs[i].rt_m;
            A3_E = vecs[i].a3e; A3_M = vecs[i].a3m; A3_W = vecs[i].a3w;
            res_E = vecs[i].rese; res_M = vecs[i].resm; res_W = vecs[i].resw;
            #1;
            chk($sformatf("v%0d_stall", i), 32'(stall), 32'(vecs[i].e_stall));
            chk($sformatf("v%0d_MCMP1D", i), 32'(MCMP1D), 32'(vecs[i].e_c1));
            chk($sformatf("v%0d_MCMP2D", i), 32'(MCMP2D), 32'(vecs[i].e_c2));
            chk($sformatf("v%0d_MALUAE", i), 32'(MALUAE), 32'(vecs[i].e_ae));
            chk($sformatf("v%0d_MALUBE", i), 32'(MALUBE), 32'(vecs[i].e_be));
            chk($sformatf("v%0d_MWDM", i), 32'(MWDM), 32'(vecs[i].e_wd));
        end
        clear_pipe();

        // Divide: busy 10 cycles, mfhi in D stalls throughout, including the start cycle.
        step();
        md_use_D = 1; md_start_E = 1; md_div_E = 1;
        #1;
        chk("div_start_stall", 32'(stall), 32'd1);
        step();
        md_start_E = 0;
        busy_window("div", 10);

        // Multiply interrupted by reset at busy cycle 3.
        md_use_D = 0; md_start_E = 1; md_div_E = 0;
        step();
        md_start_E = 0;
        chk("mul_busy1", 32'(md_busy), 32'd1);
        step();
        step();
        chk("mul_busy3", 32'(md_busy), 32'd1);
        reset = 1;
        step();
        reset = 0;
        chk("mul_rst_busy", 32'(md_busy), 32'd0);

        // Multiply restarted by a divide: busy 10 cycles from the restart.
        md_use_D = 1; md_start_E = 1; md_div_E = 0;
        step();
        md_start_E = 0;
        step();
        step();
        md_start_E = 1; md_div_E = 1;
        step();
        md_start_E = 0;
        busy_window("restart", 10);
        md_use_D = 0;

        // Stall-cycle counter: clean start, 7 stalled edges, then reset.
        reset = 1;
        step();
        reset = 0;
        chk("perf_zero", stall_cnt, 32'd0);
        rs_D = 1; tuse_rs_D = 0; A3_E = 1; res_E = 2;
        for (int k = 0; k < 7; k++) step();
        clear_pipe();
        #1;
        chk("perf_seven", stall_cnt, EXP_PERF7);
        step();
        chk("perf_hold", stall_cnt, EXP_PERF7);
        reset = 1;
        step();
        reset = 0;
        chk("perf_reset", stall_cnt, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
